// File: rtl/render_pkg.sv
// Shared display geometry and pixel types
// for the pixel renderer slice.
package render_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int BOX_W    = 32;
  localparam int BOX_H    = 32;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/display_timing.sv
// Raster counters, active-area enable and
// the last-pixel-of-frame strobe.
module display_timing #(
  parameter int H_ACTIVE = render_pkg::H_ACTIVE,
  parameter int H_TOTAL  = render_pkg::H_TOTAL,
  parameter int V_ACTIVE = render_pkg::V_ACTIVE,
  parameter int V_TOTAL  = render_pkg::V_TOTAL
) (
  input  logic               clk_pix,
  input  logic               sim_rst,
  output render_pkg::coord_t cx,
  output render_pkg::coord_t cy,
  output logic               de,
  output logic               frame_end
);
  import render_pkg::*;

  localparam coord_t HACT = coord_t'(H_ACTIVE);
  localparam coord_t VACT = coord_t'(V_ACTIVE);
  localparam coord_t HMAX = coord_t'(H_TOTAL - 1);
  localparam coord_t VMAX = coord_t'(V_TOTAL - 1);
  localparam coord_t ONE  = coord_t'(1);

  logic h_end;
  logic v_end;

  assign h_end = (cx == HMAX);
  assign v_end = (cy == VMAX);

  // Pixel and line counters; cy steps when cx wraps.
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      cx <= '0;
      cy <= '0;
    end else begin
      cx <= h_end ? '0 : cx + ONE;
      if (h_end)
        cy <= v_end ? '0 : cy + ONE;
    end
  end

  assign de        = (cx < HACT) && (cy < VACT);
  assign frame_end = h_end && v_end;
endmodule

// File: rtl/pixel_renderer.sv
// Box rasteriser: per-frame position latch,
// hit test and one-stage output register.
module pixel_renderer #(
  parameter int H_ACTIVE = render_pkg::H_ACTIVE,
  parameter int H_TOTAL  = render_pkg::H_TOTAL,
  parameter int V_ACTIVE = render_pkg::V_ACTIVE,
  parameter int V_TOTAL  = render_pkg::V_TOTAL,
  parameter int BOX_W    = render_pkg::BOX_W,
  parameter int BOX_H    = render_pkg::BOX_H
) (
  input  logic        clk_pix,
  input  logic        sim_rst,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [23:0] box_rgb,
  input  logic [23:0] bg_rgb,
  output logic        frame_start,
  output logic        line_start,
  output logic [9:0]  sdl_sx,
  output logic [9:0]  sdl_sy,
  output logic        sdl_de,
  output logic [7:0]  sdl_r,
  output logic [7:0]  sdl_g,
  output logic [7:0]  sdl_b
);
  import render_pkg::*;

  coord_t      cx;
  coord_t      cy;
  coord_t      lat_x;
  coord_t      lat_y;
  logic        de;
  logic        frame_end;
  logic        hit;
  logic [10:0] x_end;
  logic [10:0] y_end;
  rgb_t        pix;

  display_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_timing (
    .clk_pix   (clk_pix),
    .sim_rst   (sim_rst),
    .cx        (cx),
    .cy        (cy),
    .de        (de),
    .frame_end (frame_end)
  );

  // Take a new position only on the last pixel of a frame.
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      lat_x <= '0;
      lat_y <= '0;
    end else if (frame_end) begin
      lat_x <= pos_x;
      lat_y <= pos_y;
    end
  end

  // 11-bit box extents so edge boxes clip, never wrap.
  assign x_end = {1'b0, lat_x} + 11'(BOX_W);
  assign y_end = {1'b0, lat_y} + 11'(BOX_H);

  assign hit = (cx >= lat_x) && ({1'b0, cx} < x_end)
            && (cy >= lat_y) && ({1'b0, cy} < y_end);

  // Colour select; blanking forces black.
  always_comb begin
    pix = '0;
    if (de)
      pix = hit ? rgb_t'(box_rgb) : rgb_t'(bg_rgb);
  end

  // Single output stage aligning all stream signals.
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      sdl_sx      <= '0;
      sdl_sy      <= '0;
      sdl_de      <= 1'b0;
      sdl_r       <= '0;
      sdl_g       <= '0;
      sdl_b       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      sdl_sx      <= cx;
      sdl_sy      <= cy;
      sdl_de      <= de;
      sdl_r       <= pix.r;
      sdl_g       <= pix.g;
      sdl_b       <= pix.b;
      frame_start <= (cx == '0) && (cy == '0);
      line_start  <= (cx == '0);
    end
  end
endmodule
